// File: rtl/hndsk_serializer.sv
// Valid/ready width converter: splits each D_WIDTH input word into RATIO
// S_WIDTH beats, LSB slice first, and flags the final beat of every word.
module hndsk_serializer #(
    parameter int D_WIDTH = 16,
    parameter int S_WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vldi,
    output logic               rdyi,
    input  logic [D_WIDTH-1:0] datai,
    output logic               vldo,
    input  logic               rdyo,
    output logic [S_WIDTH-1:0] datao,
    output logic               lasto
);

    localparam int RATIO = D_WIDTH / S_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    if (((D_WIDTH % S_WIDTH) != 0) || (S_WIDTH >= D_WIDTH)) begin : g_bad_params
        $error("hndsk_serializer: D_WIDTH must be a multiple of S_WIDTH and wider than it");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_n_s;
    logic [D_WIDTH-1:0] shreg_r;
    logic [D_WIDTH-1:0] shreg_n_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_n_s;
    logic               last_s;

    // rdyi only looks at rdyo, never at vldi, so no loop forms through the source.
    assign last_s = (state_r == SEND) && (cnt_r == CNT_LAST);
    assign vldo   = (state_r == SEND);
    assign lasto  = last_s;
    assign datao  = shreg_r[S_WIDTH-1:0];
    assign rdyi   = (state_r == EMPTY) || (rdyo && last_s);

    // State, shift register and beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
            shreg_r <= {D_WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_n_s;
            shreg_r <= shreg_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // Next-state logic: load, shift on accepted beat, or reload back-to-back.
    always_comb begin
        state_n_s = state_r;
        shreg_n_s = shreg_r;
        cnt_n_s   = cnt_r;
        case (state_r)
            EMPTY: begin
                if (vldi) begin
                    shreg_n_s = datai;
                    cnt_n_s   = {CNT_W{1'b0}};
                    state_n_s = SEND;
                end else begin
                    state_n_s = EMPTY;
                end
            end
            SEND: begin
                if (!rdyo) begin
                    state_n_s = SEND;
                end else if (cnt_r != CNT_LAST) begin
                    shreg_n_s = shreg_r >> S_WIDTH;
                    cnt_n_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (vldi) begin
                    // Last beat leaves while the next word arrives: no bubble.
                    shreg_n_s = datai;
                    cnt_n_s   = {CNT_W{1'b0}};
                    state_n_s = SEND;
                end else begin
                    shreg_n_s = {D_WIDTH{1'b0}};
                    cnt_n_s   = {CNT_W{1'b0}};
                    state_n_s = EMPTY;
                end
            end
            default: begin
                shreg_n_s = {D_WIDTH{1'b0}};
                cnt_n_s   = {CNT_W{1'b0}};
                state_n_s = EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_hndsk_serializer.sv
// Directed bench for hndsk_serializer: 16/4 scenarios plus a random
// scoreboard sweep on 8/1 and 32/16 instances.
module tb_hndsk_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        vldi = 1'b0, rdyo = 1'b0, rdyi, vldo, lasto;
    logic [15:0] datai = 16'h0;
    logic [3:0]  datao;

    logic        vldi8 = 1'b0, rdyo8 = 1'b0, rdyi8, vldo8, lasto8;
    logic [7:0]  datai8 = 8'h0;
    logic [0:0]  datao8;

    logic        vldi32 = 1'b0, rdyo32 = 1'b0, rdyi32, vldo32, lasto32;
    logic [31:0] datai32 = 32'h0;
    logic [15:0] datao32;

    int errors = 0;
    int checks = 0;

    hndsk_serializer #(.D_WIDTH(16), .S_WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .vldi(vldi), .rdyi(rdyi), .datai(datai),
        .vldo(vldo), .rdyo(rdyo), .datao(datao), .lasto(lasto));

    hndsk_serializer #(.D_WIDTH(8), .S_WIDTH(1)) u_dut8 (
        .clk(clk), .rst(rst), .vldi(vldi8), .rdyi(rdyi8), .datai(datai8),
        .vldo(vldo8), .rdyo(rdyo8), .datao(datao8), .lasto(lasto8));

    hndsk_serializer #(.D_WIDTH(32), .S_WIDTH(16)) u_dut32 (
        .clk(clk), .rst(rst), .vldi(vldi32), .rdyi(rdyi32), .datai(datai32),
        .vldo(vldo32), .rdyo(rdyo32), .datao(datao32), .lasto(lasto32));

    task automatic test_reset();
        #2;
        checks++;
        if ({vldo, lasto, datao, rdyi} !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset: vldo=%b lasto=%b datao=%h rdyi=%b, want 0 0 0 1", vldo, lasto, datao, rdyi);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({vldo, lasto, datao, rdyi} !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release: vldo=%b lasto=%b datao=%h rdyi=%b, want 0 0 0 1", vldo, lasto, datao, rdyi);
        end
    endtask

    task automatic test_single_word();
        logic [3:0] exp [4] = '{4'hD, 4'hC, 4'hB, 4'hA};
        @(negedge clk);
        vldi = 1'b1; datai = 16'hABCD; rdyo = 1'b1;
        #1;
        checks++;
        if (rdyi !== 1'b1) begin errors++; $display("FAIL single_rdyi_idle: got %b want 1", rdyi); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vldi = 1'b0;
            #1;
            checks++;
            if ({vldo, datao, lasto, rdyi} !== {1'b1, exp[i], (i == 3), (i == 3)}) begin
                errors++;
                $display("FAIL single_beat%0d: vldo=%b datao=%h lasto=%b rdyi=%b, want 1 %h %b %b",
                         i, vldo, datao, lasto, rdyi, exp[i], (i == 3), (i == 3));
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if ({vldo, lasto, datao, rdyi} !== {1'b0, 1'b0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL single_after: vldo=%b lasto=%b datao=%h rdyi=%b, want 0 0 0 1", vldo, lasto, datao, rdyi);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp [8] = '{4'h4, 4'h3, 4'h2, 4'h1, 4'h8, 4'h7, 4'h6, 4'h5};
        @(negedge clk);
        vldi = 1'b1; datai = 16'h1234; rdyo = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vldi = (i < 4); datai = 16'h5678;
            #1;
            checks++;
            if ({vldo, datao, lasto, rdyi} !== {1'b1, exp[i], (i == 3 || i == 7), (i == 3 || i == 7)}) begin
                errors++;
                $display("FAIL b2b_beat%0d: vldo=%b datao=%h lasto=%b rdyi=%b, want 1 %h", i, vldo, datao, lasto, rdyi, exp[i]);
            end
        end
        @(negedge clk);
        vldi = 1'b0;
        #1;
        checks++;
        if (vldo !== 1'b0) begin errors++; $display("FAIL b2b_after: vldo=%b want 0", vldo); end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp [7] = '{4'hD, 4'hC, 4'hC, 4'hC, 4'hC, 4'hB, 4'hA};
        @(negedge clk);
        vldi = 1'b1; datai = 16'hABCD; rdyo = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            vldi = 1'b0;
            rdyo = !(i >= 1 && i <= 3);
            #1;
            checks++;
            if ({vldo, datao, lasto} !== {1'b1, exp[i], (i == 6)}) begin
                errors++;
                $display("FAIL bp_beat%0d: vldo=%b datao=%h lasto=%b, want 1 %h %b", i, vldo, datao, lasto, exp[i], (i == 6));
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (vldo !== 1'b0) begin errors++; $display("FAIL bp_after: vldo=%b want 0 (duplicate beat)", vldo); end
    endtask

    task automatic test_busy_input();
        logic [3:0] exp [4] = '{4'hD, 4'hC, 4'hB, 4'hA};
        @(negedge clk);
        vldi = 1'b1; datai = 16'hABCD; rdyo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vldi = (i < 3);
            datai = 16'($urandom);
            #1;
            checks++;
            if ({vldo, datao, rdyi} !== {1'b1, exp[i], (i == 3)}) begin
                errors++;
                $display("FAIL busy_beat%0d: vldo=%b datao=%h rdyi=%b, want 1 %h %b", i, vldo, datao, rdyi, exp[i], (i == 3));
            end
        end
        @(negedge clk);
        vldi = 1'b0;
        #1;
        checks++;
        if (vldo !== 1'b0) begin errors++; $display("FAIL busy_after: vldo=%b want 0", vldo); end
    endtask

    task automatic test_reset_mid_word();
        logic [3:0] exp [4] = '{4'h1, 4'hF, 4'h0, 4'h0};
        @(negedge clk);
        vldi = 1'b1; datai = 16'hABCD; rdyo = 1'b1;
        @(negedge clk);
        vldi = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (datao !== 4'hC) begin errors++; $display("FAIL rstmid_pre: datao=%h want c", datao); end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({vldo, datao, rdyi, lasto} !== {1'b0, 4'h0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_async: vldo=%b datao=%h rdyi=%b lasto=%b, want 0 0 1 0", vldo, datao, rdyi, lasto);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (vldo !== 1'b0) begin errors++; $display("FAIL rstmid_idle%0d: vldo=%b want 0", i, vldo); end
        end
        @(negedge clk);
        vldi = 1'b1; datai = 16'h00F1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vldi = 1'b0;
            #1;
            checks++;
            if ({vldo, datao, lasto} !== {1'b1, exp[i], (i == 3)}) begin
                errors++;
                $display("FAIL rstmid_next%0d: vldo=%b datao=%h lasto=%b, want 1 %h %b", i, vldo, datao, lasto, exp[i], (i == 3));
            end
        end
    endtask

    task automatic test_param_sweep();
        logic [7:0]  q8 [$];
        logic [31:0] q32 [$];
        logic [7:0]  asm8 = 8'h0;
        logic [31:0] asm32 = 32'h0;
        logic [7:0]  want8;
        logic [31:0] want32;
        int b8 = 0, b32 = 0, words = 0;
        for (int c = 0; c < 1060; c++) begin
            @(negedge clk);
            vldi8   = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            rdyo8   = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
            datai8  = 8'($urandom);
            vldi32  = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            rdyo32  = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
            datai32 = $urandom;
            #1;
            if (vldi8 && rdyi8) q8.push_back(datai8);
            if (vldi32 && rdyi32) q32.push_back(datai32);
            if (vldo8 && rdyo8) begin
                checks++;
                if (lasto8 !== (b8 == 7)) begin errors++; $display("FAIL sweep8_lasto: got %b at beat %0d", lasto8, b8); end
                asm8[b8] = datao8[0];
                if (b8 == 7) begin
                    want8 = (q8.size() > 0) ? q8.pop_front() : 8'hxx;
                    checks++; words++;
                    if (asm8 !== want8) begin errors++; $display("FAIL sweep8_word: got %h want %h", asm8, want8); end
                    b8 = 0;
                end else b8++;
            end
            if (vldo32 && rdyo32) begin
                checks++;
                if (lasto32 !== (b32 == 1)) begin errors++; $display("FAIL sweep32_lasto: got %b at beat %0d", lasto32, b32); end
                asm32[b32*16 +: 16] = datao32;
                if (b32 == 1) begin
                    want32 = (q32.size() > 0) ? q32.pop_front() : 32'hxxxxxxxx;
                    checks++; words++;
                    if (asm32 !== want32) begin errors++; $display("FAIL sweep32_word: got %h want %h", asm32, want32); end
                    b32 = 0;
                end else b32++;
            end
        end
        checks++;
        if (q8.size() != 0 || q32.size() != 0 || b8 != 0 || b32 != 0 || words < 50) begin
            errors++;
            $display("FAIL sweep_drain: pending8=%0d pending32=%0d b8=%0d b32=%0d words=%0d, want 0 0 0 0 >=50",
                     q8.size(), q32.size(), b8, b32, words);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_busy_input();
        test_reset_mid_word();
        test_param_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
